// File: rtl/uart_rx_param.sv
// UART receiver (parameterized framing) with a small receive FIFO and sticky error flags; a frame is pushed on its last stop sample, data_valid follows one cycle later.
// Backpressure: data_ready pops the head word; a push into a full FIFO with no pop drops the new word and sets overflow.
module uart_rx_param #(
    parameter int MAIN_CLK   = 100000000,
    parameter int BAUD       = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overflow,
    input  logic                 clr_status
);
    localparam int BIT_DIV = MAIN_CLK / BAUD;
    localparam int DIV_W   = $clog2(BIT_DIV);
    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam logic [DIV_W-1:0] DIV_HALF  = DIV_W'(BIT_DIV / 2);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(BIT_DIV - 1);
    localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);
    localparam logic             ODD_PAR   = (PARITY == 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    state_t                 state_q, state_d;
    logic                   rx_meta_q, rx_meta_d;
    logic                   rxs_q, rxs_d;
    logic                   rxs_prev_q, rxs_prev_d;
    logic [DIV_W-1:0]       div_q, div_d;
    logic [3:0]             bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   par_bad_q, par_bad_d;
    logic                   stop_bad_q, stop_bad_d;
    logic [AW:0]            wr_ptr_q, wr_ptr_d;
    logic [AW:0]            rd_ptr_q, rd_ptr_d;
    logic [FIFO_DEPTH-1:0][DATA_BITS-1:0] mem_q, mem_d;
    logic                   parity_err_q, parity_err_d;
    logic                   frame_err_q, frame_err_d;
    logic                   overflow_q, overflow_d;

    logic sample, push, set_par, set_frame, pop, full, empty, wr_ok;

    // Frame decoder
    always_comb begin
        rx_meta_d  = rx;
        rxs_d      = rx_meta_q;
        rxs_prev_d = rxs_q;
        state_d    = state_q;
        div_d      = div_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        par_bad_d  = par_bad_q;
        stop_bad_d = stop_bad_q;
        push       = 1'b0;
        set_par    = 1'b0;
        set_frame  = 1'b0;
        sample     = (div_q == DIV_HALF);
        if (state_q != IDLE) begin
            div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
        end
        case (state_q)
            IDLE: begin
                if (rxs_prev_q && !rxs_q) begin
                    state_d = START;
                    div_d   = '0;
                end
            end
            START: begin
                if (sample) begin
                    if (rxs_q) begin
                        state_d = IDLE;
                    end else begin
                        state_d    = DATA;
                        bit_cnt_d  = '0;
                        par_bad_d  = 1'b0;
                        stop_bad_d = 1'b0;
                    end
                end
            end
            DATA: begin
                if (sample) begin
                    shift_d = {rxs_q, shift_q[DATA_BITS-1:1]};
                    if (bit_cnt_q == DATA_LAST) begin
                        bit_cnt_d = '0;
                        state_d   = (PARITY != 0) ? PAR : STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            PAR: begin
                if (sample) begin
                    par_bad_d = ((^shift_q) ^ rxs_q) != ODD_PAR;
                    state_d   = STOP;
                end
            end
            STOP: begin
                if (sample) begin
                    // Leave on the last stop sample itself so the next start edge is never missed
                    if (bit_cnt_q == STOP_LAST) begin
                        state_d   = IDLE;
                        set_frame = stop_bad_q | ~rxs_q;
                        set_par   = par_bad_q;
                        push      = ~(stop_bad_q | ~rxs_q) & ~par_bad_q;
                    end else begin
                        bit_cnt_d  = bit_cnt_q + 1'b1;
                        stop_bad_d = stop_bad_q | ~rxs_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Receive FIFO and sticky status
    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        pop      = !empty && data_ready;
        wr_ok    = push && (!full || pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_ok) begin
            mem_d[wr_ptr_q[AW-1:0]] = shift_q;
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        parity_err_d = clr_status ? 1'b0 : parity_err_q;
        frame_err_d  = clr_status ? 1'b0 : frame_err_q;
        overflow_d   = clr_status ? 1'b0 : overflow_q;
        if (set_par)               parity_err_d = 1'b1;
        if (set_frame)             frame_err_d  = 1'b1;
        if (push && full && !pop)  overflow_d   = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            rx_meta_q    <= 1'b1;
            rxs_q        <= 1'b1;
            rxs_prev_q   <= 1'b1;
            div_q        <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            par_bad_q    <= 1'b0;
            stop_bad_q   <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            mem_q        <= '0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            rx_meta_q    <= rx_meta_d;
            rxs_q        <= rxs_d;
            rxs_prev_q   <= rxs_prev_d;
            div_q        <= div_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            par_bad_q    <= par_bad_d;
            stop_bad_q   <= stop_bad_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            mem_q        <= mem_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            overflow_q   <= overflow_d;
        end
    end

    assign data       = mem_q[rd_ptr_q[AW-1:0]];
    assign data_valid = !empty;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign overflow   = overflow_q;
endmodule

// File: doc/uart_rx_param.md
UART_RX_PARAM -- requirements
Module: uart_rx_param

Interface
REQ-001 SHALL have parameter MAIN_CLK, default 100000000, clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, line rate; BIT_DIV = MAIN_CLK/BAUD (integer division, at least 4).
REQ-003 SHALL have parameter DATA_BITS, default 8, legal range 5..9.
REQ-004 SHALL have parameter PARITY, default 0, meaning 0 none, 1 odd, 2 even.
REQ-005 SHALL have parameter STOP_BITS, default 1, legal values 1 or 2.
REQ-006 SHALL have parameter FIFO_DEPTH, default 4, a power of 2, at least 2.
REQ-007 SHALL have port clk, input, 1 bit, sole clock; all logic on its rising edge.
REQ-008 SHALL have port rst_n, input, 1 bit, reset that is asynchronous and active-low.
REQ-009 SHALL have port rx, input, 1 bit, asynchronous serial line that idles high.
REQ-010 SHALL have port data, output, DATA_BITS wide, FIFO head word.
REQ-011 SHALL have port data_valid, output, 1 bit, high when the FIFO is not empty.
REQ-012 SHALL have port data_ready, input, 1 bit, consumer accepts the head word.
REQ-013 SHALL have ports parity_err, frame_err and overflow, outputs, 1 bit each, sticky status.
REQ-014 SHALL have port clr_status, input, 1 bit, clears all sticky status bits.

Function
REQ-015 rx SHALL pass through a 2-flop synchronizer (flops reset to 1); all decoding SHALL use the synchronized value rxs.
REQ-016 FSM states SHALL be IDLE, START, DATA, PAR, STOP.
- IDLE to START SHALL occur on a 1-to-0 transition of rxs.
- Entering START SHALL clear the bit-period counter div.
REQ-017 Outside IDLE, div SHALL count 0..BIT_DIV-1 and then wrap to 0. The line SHALL be sampled only when div == BIT_DIV/2.
REQ-018 START sample of rxs == 1 SHALL return the FSM to IDLE silently (glitch reject, no status change). A sample of 0 SHALL advance to DATA.
REQ-019 DATA SHALL shift in DATA_BITS samples LSB first, then go to PAR if PARITY != 0, else to STOP.
REQ-020 PAR SHALL compare the sample against the computed parity (odd: XOR of data and parity bit == 1; even: == 0).
REQ-021 STOP SHALL take STOP_BITS samples.
- Any stop sample of 0 SHALL set frame_err and discard the frame.
- After the last stop sample the FSM SHALL return to IDLE in the same cycle, with no wait for the bit end.
REQ-022 A frame with a parity mismatch and valid stop bits SHALL set parity_err and be discarded. A frame with both errors SHALL set both bits.
REQ-023 A valid frame SHALL be pushed into the FIFO. data_valid SHALL rise on the cycle after the final stop-sample cycle.
REQ-024 Pop rule: data_valid && data_ready pops the head. The next entry, if any, SHALL appear on data the following cycle.
REQ-025 Push when full SHALL drop the new word and set overflow; FIFO contents SHALL be unchanged.
REQ-026 Simultaneous push and pop when full SHALL accept both, with no overflow.
REQ-027 Simultaneous push and pop when empty SHALL push only; no pop occurs because data_valid was low.
REQ-028 The FIFO pointers SHALL be log2(FIFO_DEPTH)+1 bits wide, with the MSB distinguishing full from empty, and SHALL wrap naturally.
REQ-029 clr_status SHALL clear all sticky bits on the next cycle. If a set and a clear fall in the same cycle, the set SHALL win.
REQ-030 data SHALL hold its value while data_valid is low; its content is then don't-care but stable.

Reset
REQ-031 When rst_n == 0, the following SHALL be forced immediately, independent of clk:
- FSM to IDLE, div = 0, shift register = 0.
- FIFO pointers = 0; data = 0, data_valid = 0.
- parity_err = frame_err = overflow = 0.
- Synchronizer flops = 1.
REQ-032 Reset mid-frame SHALL abandon the frame. After release, reception SHALL resume only on a new falling edge of rxs.

Verification
Bench parameters: MAIN_CLK=16, BAUD=1 (BIT_DIV=16), DATA_BITS=8, PARITY=2, STOP_BITS=1, FIFO_DEPTH=4, unless stated otherwise.
REQ-033 Send 0xA5 with even parity bit 0, data_ready=1 -> data=0xA5, data_valid pulses for 1 cycle, all status bits 0.
REQ-034 Send 0x01 with parity bit 0 (wrong) -> no push, parity_err=1. Then assert clr_status -> parity_err=0 the next cycle.
REQ-035 Send 0x3C with stop bit 0 -> no push, frame_err=1. Then a following 0x3C with a good frame is received correctly.
REQ-036 rx low pulse of 4 cycles -> FSM returns to IDLE after the START sample, no push, no status change.
REQ-037 With data_ready=0, send 5 frames 0x10..0x14 -> FIFO holds 0x10..0x13, overflow=1, and popping yields 0x10,0x11,0x12,0x13 in order.
REQ-038 Drop rst_n in the middle of the DATA state of frame 0x55 -> outputs zero at once. After release, frame 0x66 is received as 0x66 and nothing else is pushed.
